// File: rtl/truth_table_seq_eval.sv
// Run-time programmable multi-output truth table with a valid/ready query path
// and an exhaustive sweep mode that streams every input vector with its outputs.
module truth_table_seq_eval #(
  parameter int                            N_IN          = 4,
  parameter int                            N_OUT         = 5,
  parameter logic [(2**N_IN)*N_OUT-1:0]    DEFAULT_TABLE = '0,
  parameter logic [N_OUT-1:0]              INV_MASK      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             sweep_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_x,
  output logic [N_OUT-1:0] out_f,
  output logic             out_last,
  output logic             busy
);
  localparam int            DEPTH = 1 << N_IN;
  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    SWEEP = 1'b1;
  localparam logic [N_IN:0] LAST  = (N_IN+1)'(DEPTH-1);
  localparam logic [N_IN:0] ONE   = (N_IN+1)'(1);

  // Entry i occupies bits [i*N_OUT +: N_OUT], matching the DEFAULT_TABLE image.
  logic [DEPTH-1:0][N_OUT-1:0] tbl;
  logic [0:0]                  state;
  logic [N_IN:0]               cnt;
  logic                        adv, accept, wr, start;
  logic [N_IN-1:0]             sweep_idx;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && adv && !cfg_we && !sweep_start;
  assign accept    = in_valid && in_ready;
  assign wr        = cfg_we && (state == IDLE);
  assign start     = sweep_start && !cfg_we && (state == IDLE);
  assign sweep_idx = cnt[N_IN-1:0];
  assign busy      = (state == SWEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl       <= DEFAULT_TABLE;
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_f     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (wr) tbl[cfg_addr] <= cfg_data;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SWEEP;
            cnt   <= '0;
          end
          if (adv) begin
            out_valid <= accept;
            if (accept) begin
              out_x    <= in_x;
              out_f    <= tbl[in_x] ^ INV_MASK;
              out_last <= 1'b0;
            end
          end
        end
        default: begin
          // cnt only advances when a beat is loaded, so stalls never skip or repeat.
          if (adv) begin
            out_valid <= 1'b1;
            out_x     <= sweep_idx;
            out_f     <= tbl[sweep_idx] ^ INV_MASK;
            out_last  <= (cnt == LAST);
            cnt       <= cnt + ONE;
            if (cnt == LAST) state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_seq_eval.sv
// Directed bench for truth_table_seq_eval; a second instance checks output inversion.
module tb_truth_table_seq_eval;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we, sweep_start, in_valid, out_ready;
  logic [3:0] cfg_addr, in_x;
  logic [4:0] cfg_data;
  logic       in_ready, out_valid, out_last, busy;
  logic [3:0] out_x;
  logic [4:0] out_f;
  logic       i_in_ready, i_out_valid, i_out_last, i_busy;
  logic [3:0] i_out_x;
  logic [4:0] i_out_f;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  truth_table_seq_eval #(.N_IN(4), .N_OUT(5)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sweep_start(sweep_start), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_f(out_f),
    .out_last(out_last), .busy(busy));

  truth_table_seq_eval #(.N_IN(4), .N_OUT(5), .INV_MASK(5'h01)) dut_inv (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sweep_start(sweep_start), .in_valid(in_valid), .in_ready(i_in_ready), .in_x(in_x),
    .out_valid(i_out_valid), .out_ready(out_ready), .out_x(i_out_x), .out_f(i_out_f),
    .out_last(i_out_last), .busy(i_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects table[i]==i; optionally pokes cfg_we at entry 7 for the first cycles.
  task automatic run_sweep(input bit poke_we);
    int idx = 0;
    int cyc = 0;
    logic r;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    while (idx < 16 && cyc < 300) begin
      r         = (cyc % 7 == 6) ? 1'b1 : 1'($urandom_range(0, 1));
      out_ready = r;
      cfg_we    = poke_we && (cyc < 8);
      cfg_addr  = 4'd7;
      cfg_data  = 5'h1E;
      #1;
      if (!(out_valid && out_last)) begin
        chk("sweep_busy", busy, 1);
        chk("sweep_in_ready", in_ready, 0);
      end
      if (out_valid && r) begin
        chk("sweep_x", out_x, idx);
        chk("sweep_f", out_f, idx);
        chk("sweep_last", out_last, (idx == 15));
        idx++;
      end
      cyc++;
      tick();
    end
    cfg_we = 1'b0;
    if (idx < 16) chk("sweep_timeout", idx, 16);
    out_ready = 1'b1;
    tick();
    chk("sweep_drained_valid", out_valid, 0);
    chk("sweep_drained_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    sweep_start = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    #12 rst_n = 1'b1;
    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_f", out_f, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // write then query
    cfg_we = 1'b1; cfg_addr = 4'hA; cfg_data = 5'h13;
    tick();
    cfg_we = 1'b0; in_valid = 1'b1; in_x = 4'hA; out_ready = 1'b1;
    #1 chk("q_in_ready", in_ready, 1);
    tick();
    chk("q_valid", out_valid, 1);
    chk("q_x", out_x, 4'hA);
    chk("q_f", out_f, 5'h13);

    // backpressure hold
    out_ready = 1'b0; in_x = 4'h5;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_f", out_f, 5'h13);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    tick();
    chk("next_x", out_x, 4'h5);
    chk("next_f", out_f, 5'h00);
    in_valid = 1'b0;
    tick();
    chk("idle_clear_valid", out_valid, 0);

    // table[i] = i, then sweep under random backpressure
    for (int i = 0; i < 16; i++) begin
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = 5'(i);
      tick();
    end
    cfg_we = 1'b0;
    run_sweep(1'b0);

    // cfg_we beats in_valid; write lands
    in_valid = 1'b1; in_x = 4'h2; cfg_we = 1'b1; cfg_addr = 4'h2; cfg_data = 5'h1F;
    #1 chk("we_prio_in_ready", in_ready, 0);
    tick();
    cfg_we = 1'b0;
    #1 chk("retry_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("we_landed_x", out_x, 4'h2);
    chk("we_landed_f", out_f, 5'h1F);
    // cfg_we beats sweep_start: restore entry 2, no sweep
    cfg_we = 1'b1; cfg_addr = 4'h2; cfg_data = 5'h02; sweep_start = 1'b1;
    tick();
    cfg_we = 1'b0; sweep_start = 1'b0;
    chk("we_over_start_busy", busy, 0);
    // writes during sweep are dropped
    run_sweep(1'b1);
    run_sweep(1'b0);

    // inversion instance and reset mid-sweep stall
    sweep_start = 1'b1; out_ready = 1'b0;
    tick();
    sweep_start = 1'b0;
    tick(); tick();
    chk("stall_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    #3 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_x = 4'h3; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("default_f", out_f, 5'h00);
    chk("inv_valid", i_out_valid, 1);
    chk("inv_x", i_out_x, 4'h3);
    chk("inv_f", i_out_f, 5'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
